// File: rtl/id_ex_hazard_ctrl.sv
// ============================================================================
//  Module   : id_ex_hazard_ctrl
//  Purpose  : Pipeline hazard controller. Resolves load-use, taken branch,
//             jump and data-memory wait conditions into PC / IF-ID write
//             enables, IF/ID and ID/EX flushes and a whole-pipe freeze.
//             A two-state FSM tracks multi-cycle memory waits with a
//             timeout, and saturating counters record stalls and flushes.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module id_ex_hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_use_rs,
  input  logic             ID_use_rt,
  input  logic             EX_MemtoReg,
  input  logic             EX_RegWr,
  input  logic [4:0]       EX_rt,
  input  logic             EX_branch_taken,
  input  logic             ID_jump,
  input  logic             MEM_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             pipe_freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // Wait counter is 8 bits wide because TIMEOUT is limited to 255.
  localparam logic [7:0]       TIMEOUT_LIM = 8'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic w_load_use;
  logic w_mem_wait;
  logic w_stall_evt;
  logic w_flush_evt;

  // A load in EX whose destination is a source of the ID instruction.
  assign w_load_use = EX_MemtoReg & EX_RegWr & (EX_rt != 5'd0) &
                      ((ID_use_rs & (ID_rs == EX_rt)) |
                       (ID_use_rt & (ID_rt == EX_rt)));

  // Memory stall covers both the waiting state and the first cycle of a
  // not-yet-ready access, so the freeze starts without a cycle of lag.
  assign w_mem_wait = (state_q == MEM_WAIT) |
                      ((state_q == RUN) & MEM_req & ~mem_ready);

  // Prioritised control decode; everything is held low while in reset.
  always_comb begin
    pc_write    = 1'b0;
    IF_ID_write = 1'b0;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    pipe_freeze = 1'b0;
    w_stall_evt = 1'b0;
    w_flush_evt = 1'b0;
    if (!reset) begin
      if (w_mem_wait) begin
        // Branch, load-use and jump are deferred until memory releases.
        pipe_freeze = 1'b1;
        w_stall_evt = 1'b1;
      end else if (EX_branch_taken) begin
        // A coincident load-use instruction is on the wrong path and is
        // flushed along with everything else, so no stall is charged.
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
        pc_write    = 1'b1;
        IF_ID_write = 1'b1;
        w_flush_evt = 1'b1;
      end else if (w_load_use) begin
        // Single bubble: the bubble itself clears EX_MemtoReg next cycle.
        ID_EX_flush = 1'b1;
        w_stall_evt = 1'b1;
      end else if (ID_jump) begin
        IF_ID_flush = 1'b1;
        pc_write    = 1'b1;
        IF_ID_write = 1'b1;
        w_flush_evt = 1'b1;
      end else begin
        pc_write    = 1'b1;
        IF_ID_write = 1'b1;
      end
    end
  end

  // Next-state logic for the memory-wait FSM, timeout flag and counters.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    stall_d    = stall_q;
    flush_d    = flush_q;

    case (state_q)
      RUN: begin
        wait_cnt_d = 8'd0;
        if (MEM_req && !mem_ready) begin
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          // This cycle is still frozen; the pipe advances on the next one.
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else if ((wait_cnt_q + 8'd1) == TIMEOUT_LIM) begin
          // Give up on the access and let the pipe run; flag stays set.
          state_d    = RUN;
          wait_cnt_d = 8'd0;
          timeout_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = 8'd0;
      end
    endcase

    if (w_stall_evt && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_ONE;
    end
    if (w_flush_evt && (flush_q != CNT_MAX)) begin
      flush_d = flush_q + CNT_ONE;
    end
  end

  // State register; asynchronous reset aborts any wait in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_hazard_ctrl.sv
// ============================================================================
//  Module   : tb_id_ex_hazard_ctrl
//  Purpose  : Self-checking bench for id_ex_hazard_ctrl: directed scenarios
//             plus a randomized run against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_id_ex_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] ID_rs, ID_rt, EX_rt;
  logic ID_use_rs, ID_use_rt, EX_MemtoReg, EX_RegWr;
  logic EX_branch_taken, ID_jump, MEM_req, mem_ready;
  logic pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_freeze, mem_timeout;
  logic [CNT_W-1:0] stall_count, flush_count;
  logic [4:0] ctl;

  int n_checks = 0;
  int n_fail   = 0;

  // Packed view: {pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_freeze}
  assign ctl = {pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_freeze};

  always #5 clk = ~clk;

  id_ex_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt),
    .EX_MemtoReg(EX_MemtoReg), .EX_RegWr(EX_RegWr), .EX_rt(EX_rt),
    .EX_branch_taken(EX_branch_taken), .ID_jump(ID_jump),
    .MEM_req(MEM_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_flush(ID_EX_flush), .pipe_freeze(pipe_freeze), .mem_timeout(mem_timeout),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  task automatic idle();
    ID_rs = 5'd0; ID_rt = 5'd0; EX_rt = 5'd0;
    ID_use_rs = 1'b0; ID_use_rt = 1'b0; EX_MemtoReg = 1'b0; EX_RegWr = 1'b0;
    EX_branch_taken = 1'b0; ID_jump = 1'b0; MEM_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); reset = 1'b1;
    tick(); tick();
    reset = 1'b0; #1;
  endtask

  task automatic test_reset();
    idle(); reset = 1'b1; #1;
    n_checks++; if (ctl !== 5'b00000) begin n_fail++; $display("FAIL reset_ctl: got %b want 00000", ctl); end
    tick();
    n_checks++; if (stall_count !== 4'd0 || flush_count !== 4'd0 || mem_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_regs: got stall=%0d flush=%0d to=%b want 0 0 0", stall_count, flush_count, mem_timeout); end
    reset = 1'b0; #1;
    n_checks++; if (ctl !== 5'b11000) begin n_fail++; $display("FAIL release_ctl: got %b want 11000", ctl); end
    tick();
    n_checks++; if (stall_count !== 4'd0 || flush_count !== 4'd0) begin n_fail++; $display("FAIL idle_counts: got stall=%0d flush=%0d want 0 0", stall_count, flush_count); end
  endtask

  task automatic test_load_use();
    EX_MemtoReg = 1'b1; EX_RegWr = 1'b1; EX_rt = 5'd5; ID_rs = 5'd5; ID_use_rs = 1'b1; #1;
    n_checks++; if (ctl !== 5'b00010) begin n_fail++; $display("FAIL lu_ctl: got %b want 00010", ctl); end
    tick();
    EX_MemtoReg = 1'b0; #1;  // bubble now in EX
    n_checks++; if (ctl !== 5'b11000) begin n_fail++; $display("FAIL lu_one_bubble: got %b want 11000", ctl); end
    n_checks++; if (stall_count !== 4'd1) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_count); end
    EX_MemtoReg = 1'b1; EX_rt = 5'd0; ID_rs = 5'd0; #1;
    n_checks++; if (ctl !== 5'b11000) begin n_fail++; $display("FAIL lu_r0_ctl: got %b want 11000", ctl); end
    tick();
    n_checks++; if (stall_count !== 4'd1) begin n_fail++; $display("FAIL lu_r0_cnt: got %0d want 1", stall_count); end
    idle(); #1;
  endtask

  task automatic test_branch_lu();
    EX_MemtoReg = 1'b1; EX_RegWr = 1'b1; EX_rt = 5'd9; ID_rt = 5'd9; ID_use_rt = 1'b1;
    EX_branch_taken = 1'b1; #1;
    n_checks++; if (ctl !== 5'b11110) begin n_fail++; $display("FAIL br_lu_ctl: got %b want 11110", ctl); end
    tick(); idle(); #1;
    n_checks++; if (flush_count !== 4'd1 || stall_count !== 4'd1) begin n_fail++; $display("FAIL br_lu_cnt: got flush=%0d stall=%0d want 1 1", flush_count, stall_count); end
    ID_jump = 1'b1; #1;
    n_checks++; if (ctl !== 5'b11100) begin n_fail++; $display("FAIL jump_ctl: got %b want 11100", ctl); end
    tick(); idle(); #1;
    n_checks++; if (flush_count !== 4'd2) begin n_fail++; $display("FAIL jump_cnt: got %0d want 2", flush_count); end
  endtask

  task automatic test_mem_wait();
    MEM_req = 1'b1; mem_ready = 1'b0; EX_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (ctl !== 5'b00001) begin n_fail++; $display("FAIL wait_ctl[%0d]: got %b want 00001", i, ctl); end
      tick();
    end
    mem_ready = 1'b1; #1;
    n_checks++; if (ctl !== 5'b00001) begin n_fail++; $display("FAIL wait_ready_ctl: got %b want 00001", ctl); end
    tick(); idle(); #1;
    n_checks++; if (ctl !== 5'b11000) begin n_fail++; $display("FAIL wait_release_ctl: got %b want 11000", ctl); end
    n_checks++; if (stall_count !== 4'd5 || flush_count !== 4'd2) begin n_fail++; $display("FAIL wait_cnt: got stall=%0d flush=%0d want 5 2", stall_count, flush_count); end
  endtask

  task automatic test_timeout();
    MEM_req = 1'b1; mem_ready = 1'b0;
    // One entry cycle in RUN plus TIMEOUT cycles in MEM_WAIT.
    for (int i = 0; i < TIMEOUT + 1; i++) begin
      #1;
      n_checks++; if (mem_timeout !== 1'b0 || ctl !== 5'b00001) begin n_fail++; $display("FAIL to_early[%0d]: got to=%b ctl=%b want 0 00001", i, mem_timeout, ctl); end
      tick();
    end
    MEM_req = 1'b0; #1;
    n_checks++; if (mem_timeout !== 1'b1) begin n_fail++; $display("FAIL to_set: got %b want 1", mem_timeout); end
    n_checks++; if (ctl !== 5'b11000) begin n_fail++; $display("FAIL to_run_ctl: got %b want 11000", ctl); end
    tick(); tick();
    n_checks++; if (mem_timeout !== 1'b1 || stall_count !== 4'd10) begin n_fail++; $display("FAIL to_sticky: got to=%b stall=%0d want 1 10", mem_timeout, stall_count); end
  endtask

  task automatic test_reset_mid_wait();
    MEM_req = 1'b1; mem_ready = 1'b0;
    tick(); tick();
    n_checks++; if (ctl !== 5'b00001) begin n_fail++; $display("FAIL rmw_pre: got %b want 00001", ctl); end
    #2 reset = 1'b1; #1;
    n_checks++; if (ctl !== 5'b00000 || mem_timeout !== 1'b0 || stall_count !== 4'd0 || flush_count !== 4'd0) begin n_fail++; $display("FAIL rmw_async: got ctl=%b to=%b stall=%0d flush=%0d want 00000 0 0 0", ctl, mem_timeout, stall_count, flush_count); end
    tick();
    idle(); reset = 1'b0; #1;
    n_checks++; if (ctl !== 5'b11000) begin n_fail++; $display("FAIL rmw_resume: got %b want 11000", ctl); end
    ID_jump = 1'b1; tick(); idle(); #1;
    n_checks++; if (flush_count !== 4'd1) begin n_fail++; $display("FAIL rmw_jump: got %0d want 1", flush_count); end
  endtask

  // Randomized run against a behavioural model of the controller.
  task automatic test_random();
    bit  m_wait = 0, m_to = 0, waiting, hazard, st, fl;
    int  m_wc = 0, m_stall = 0, m_flush = 0;
    logic [4:0] exp_ctl;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      ID_rs = 5'($urandom_range(0, 3)); ID_rt = 5'($urandom_range(0, 3));
      EX_rt = 5'($urandom_range(0, 3));
      ID_use_rs = 1'($urandom_range(0, 1)); ID_use_rt = 1'($urandom_range(0, 1));
      EX_MemtoReg = 1'($urandom_range(0, 1)); EX_RegWr = ($urandom_range(0, 3) != 0);
      EX_branch_taken = ($urandom_range(0, 5) == 0); ID_jump = ($urandom_range(0, 5) == 0);
      MEM_req = ($urandom_range(0, 4) == 0);
      mem_ready = (cyc < 200) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      #1;
      waiting = m_wait || (MEM_req && !mem_ready);
      hazard  = EX_MemtoReg && EX_RegWr && (EX_rt != 0) &&
                ((ID_use_rs && ID_rs == EX_rt) || (ID_use_rt && ID_rt == EX_rt));
      if (waiting)              exp_ctl = 5'b00001;
      else if (EX_branch_taken) exp_ctl = 5'b11110;
      else if (hazard)          exp_ctl = 5'b00010;
      else if (ID_jump)         exp_ctl = 5'b11100;
      else                      exp_ctl = 5'b11000;
      n_checks++; if (ctl !== exp_ctl) begin n_fail++; $display("FAIL rnd_ctl cyc %0d: got %b want %b", cyc, ctl, exp_ctl); end
      n_checks++; if (stall_count !== 4'(m_stall) || flush_count !== 4'(m_flush) || mem_timeout !== m_to) begin n_fail++; $display("FAIL rnd_regs cyc %0d: got stall=%0d flush=%0d to=%b want %0d %0d %b", cyc, stall_count, flush_count, mem_timeout, m_stall, m_flush, m_to); end
      st = waiting || (!EX_branch_taken && hazard);
      fl = !waiting && (EX_branch_taken || ID_jump);
      if (st) m_stall = (m_stall == CMAX) ? CMAX : m_stall + 1;
      if (fl) m_flush = (m_flush == CMAX) ? CMAX : m_flush + 1;
      if (m_wait) begin
        if (mem_ready) begin m_wait = 0; m_wc = 0; end
        else begin
          m_wc++;
          if (m_wc == TIMEOUT) begin m_to = 1; m_wait = 0; m_wc = 0; end
        end
      end else if (MEM_req && !mem_ready) m_wait = 1;
      tick();
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(); reset = 1'b1;
    test_reset();
    test_load_use();
    test_branch_lu();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_ex_hazard_ctrl.md
Name: id_ex_hazard_ctrl

Overview:
- Pipeline hazard controller and producer of the ID_EX_flush control consumed by the ID/EX pipeline register.
- Detects load-use hazards, taken branches/jumps and data-memory wait states.
- Generates PC/IF-ID write enables, IF/ID and ID/EX flushes, and a whole-pipe freeze.
- Keeps a small FSM for multi-cycle memory waits with a timeout, plus saturating stall/flush performance counters.

Parameters:
- CNT_W, 16, width of the stall_count and flush_count performance counters.
- TIMEOUT, 64, maximum consecutive MEM_WAIT cycles before the error flag is raised; legal range 2..255.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ID_rs  in  5  rs field of the instruction in ID.
- ID_rt  in  5  rt field of the instruction in ID.
- ID_use_rs  in  1  ID instruction reads rs.
- ID_use_rt  in  1  ID instruction reads rt.
- EX_MemtoReg  in  1  instruction in EX is a load.
- EX_RegWr  in  1  instruction in EX writes the register file.
- EX_rt  in  5  destination register of the load in EX.
- EX_branch_taken  in  1  branch resolved taken in EX.
- ID_jump  in  1  jump decoded in ID.
- MEM_req  in  1  MEM stage is accessing data memory this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC update enable.
- IF_ID_write  out  1  IF/ID register load enable.
- IF_ID_flush  out  1  zero the IF/ID register.
- ID_EX_flush  out  1  insert a bubble into ID/EX.
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- mem_timeout  out  1  sticky error flag.
- stall_count  out  CNT_W  saturating count of stall cycles.
- flush_count  out  CNT_W  saturating count of flush events.

Behaviour:
- States: RUN, MEM_WAIT. Reset forces state RUN, wait counter 0, mem_timeout 0, both counters 0.
- While reset is asserted, all combinational outputs are 0 except pc_write=0 and IF_ID_write=0.
- Control outputs are combinational from the current state and inputs. State, counters and flags update on the rising clk edge.
- Load-use (lu) = EX_MemtoReg & EX_RegWr & (EX_rt != 0) & ((ID_use_rs & ID_rs == EX_rt) | (ID_use_rt & ID_rt == EX_rt)).
- Priority, highest first: memory wait > branch taken > load-use > jump > normal.
- Memory wait (MEM_WAIT, or RUN with MEM_req & !mem_ready):
  - pipe_freeze=1, pc_write=0, IF_ID_write=0.
  - ID_EX_flush=0 and IF_ID_flush=0; branch, load-use and jump are ignored until released.
  - Counts as a stall cycle.
- Branch taken (EX_branch_taken): IF_ID_flush=1, ID_EX_flush=1, pc_write=1, IF_ID_write=1. Counts as one flush event.
- Load-use: pc_write=0, IF_ID_write=0, ID_EX_flush=1. Exactly one bubble per hazard; the bubble clears EX_MemtoReg on the next cycle. Counts as a stall cycle.
- Jump: IF_ID_flush=1, pc_write=1, IF_ID_write=1. Counts as a flush event.
- Normal: pc_write=1, IF_ID_write=1, all flush/freeze outputs 0.
- RUN -> MEM_WAIT when MEM_req & !mem_ready. MEM_req & mem_ready in RUN costs no wait.
- MEM_WAIT -> RUN in the cycle mem_ready=1. That cycle is still frozen; the pipe advances on the following cycle.
- Wait counter: increments each MEM_WAIT cycle and resets to 0 on leaving MEM_WAIT.
- Timeout: reaching TIMEOUT while still waiting sets mem_timeout=1 (sticky until reset) and forces state to RUN.
- Counters: stall_count and flush_count saturate at all-ones and do not wrap.
- Simultaneous events: branch taken together with load-use is treated as the branch (the load-use instruction is flushed), counting one flush and no stall.
- Reset mid-MEM_WAIT aborts the wait immediately (asynchronous); all registered state returns to its reset value.

Test Plan:
- Release reset, idle inputs -> pc_write=1, IF_ID_write=1, all other outputs 0, counters 0.
- Load-use: EX_MemtoReg=1, EX_RegWr=1, EX_rt=5, ID_rs=5, ID_use_rs=1 for one cycle -> pc_write=0, IF_ID_write=0, ID_EX_flush=1 for exactly one cycle; stall_count=1. Repeat with EX_rt=0 -> no stall.
- EX_branch_taken=1 simultaneously with a load-use match -> IF_ID_flush=1, ID_EX_flush=1, pc_write=1; flush_count=1, stall_count unchanged.
- MEM_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> pipe_freeze=1 for 4 cycles, then released; stall_count=4; branch asserted during the wait causes no flush.
- TIMEOUT=4, MEM_req=1, mem_ready held 0 -> after 4 wait cycles mem_timeout=1 and stays 1; state returns to RUN.
- Assert reset in cycle 2 of a MEM_WAIT -> outputs drop immediately to reset values, mem_timeout=0, counters 0; after release, normal operation resumes.
